// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types for the FIFO write arbiter: FSM state, FIFO fill status and
// the round-robin successor helper.
package libfifo_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic full;
    logic empty;
  } fill_status_t;

  // Index that follows idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Write-side link to a FIFO: data/strobe toward the FIFO, fill status back.
interface fifoConnect #(
  parameter int WIDTH = 32
) ();
  import libfifo_pkg::*;

  logic [WIDTH-1:0] datain;
  logic             write;
  logic             read;
  fill_status_t     fillStatus;

  modport reader (output datain, output write, output read, input fillStatus);
  modport master (output datain, output write, output read, input fillStatus);
  modport slave  (input datain, input write, input read, output fillStatus);

endinterface

// File: rtl/fifo_write_arbiter_rr_select.sv
// Round-robin priority select: first set req bit strictly after rr_ptr,
// wrapping, so the last grant holder has the lowest priority.
module rr_select
  import libfifo_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] index,
  output logic                    valid
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] cand_v;
  logic          hit_v;

  // Walk the ring once starting at rr_ptr+1 and latch the first hit.
  always_comb begin
    cand_v = rr_ptr;
    hit_v  = 1'b0;
    index  = '0;
    valid  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_v = PW'(rr_next(32'(cand_v), 32'(NREQ)));
      hit_v  = req[cand_v] & ~valid;
      index  = hit_v ? cand_v : index;
      valid  = valid | hit_v;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter multiplexing NREQ word streams into one FIFO write
// port, holding each grant for up to MAXBURST words or until packet end.
module fifo_write_arbiter
  import libfifo_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            last,
  input  logic [NREQ-1:0][WIDTH-1:0] data,
  output logic [NREQ-1:0]            ack,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy,
  fifoConnect.reader                 link
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic [PW-1:0]    sel_index_s;
  logic             sel_valid_s;
  logic [NREQ-1:0]  ack_s;
  logic             write_s;
  logic [WIDTH-1:0] datain_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             unused_status_s;

  rr_select #(
    .NREQ (NREQ)
  ) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .index  (sel_index_s),
    .valid  (sel_valid_s)
  );

  assign cnt_inc_s       = burst_cnt_q + CW'(1);
  assign unused_status_s = link.fillStatus.empty;

  // Next-state and same-cycle write strobe; ack is combinational so a word
  // moves on the edge where the requester offers it.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    ack_s       = '0;
    write_s     = 1'b0;
    datain_s    = '0;
    case (state_q)
      ARB: begin
        if (sel_valid_s) begin
          owner_d     = sel_index_s;
          burst_cnt_d = '0;
          state_d     = BURST;
        end else begin
          state_d = ARB;
        end
      end
      BURST: begin
        datain_s = data[owner_q];
        if (!req[owner_q]) begin
          state_d  = ARB;
          rr_ptr_d = owner_q;
        end else if (!link.fillStatus.full) begin
          ack_s[owner_q] = 1'b1;
          write_s        = 1'b1;
          burst_cnt_d    = cnt_inc_s;
          if (last[owner_q] || (cnt_inc_s == CW'(MAXBURST))) begin
            state_d  = ARB;
            rr_ptr_d = owner_q;
          end else begin
            state_d = BURST;
          end
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Reset leaves rr_ptr on the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      owner_q     <= '0;
      rr_ptr_q    <= PW'(NREQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign ack         = ack_s;
  assign owner       = owner_q;
  assign busy        = (state_q == BURST);
  assign link.write  = write_s;
  assign link.read   = 1'b0;
  assign link.datain = datain_s;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scenario bench for fifo_write_arbiter: requester models feed packets, a
// negedge monitor pops expected words from a scoreboard on every write.
module tb_fifo_write_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 32;
  localparam int MAXBURST = 8;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            last;
  logic [NREQ-1:0][WIDTH-1:0] data;
  logic [NREQ-1:0]            ack;
  logic [1:0]                 owner;
  logic                       busy;

  fifoConnect #(.WIDTH(WIDTH)) link_if ();

  fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .last(last), .data(data),
    .ack(ack), .owner(owner), .busy(busy), .link(link_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int left[NREQ];
  int plen[NREQ];
  int pos[NREQ];
  int seq[NREQ];
  logic [WIDTH-1:0] sb[$];
  int grants[$];
  int blens[$];
  int wcyc[$];
  int n_writes = 0;
  int cyc = 0;
  int bl = 0;
  bit prev_busy = 1'b0;
  bit mon_en = 1'b0;

  function automatic logic [WIDTH-1:0] word(input int r, input int s);
    return {8'(r), 24'(s)};
  endfunction

  function automatic longint qcode(input int q[$]);
    longint c = 0;
    foreach (q[i]) c = c * 16 + longint'(q[i] + 1);
    return c;
  endfunction

  function automatic bit idle();
    for (int i = 0; i < NREQ; i++) if (left[i] != 0) return 1'b0;
    return !busy;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]  = (left[i] > 0);
      last[i] = (plen[i] != 0) && (pos[i] == plen[i] - 1);
      data[i] = word(i, seq[i]);
    end
  endtask

  // One clock: sample the transfer before the edge, then advance requesters.
  task automatic step();
    logic [NREQ-1:0] a;
    @(negedge clk);
    a = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (a[i]) begin
        seq[i]++;
        left[i]--;
        if (last[i]) pos[i] = 0;
        else pos[i]++;
      end
    end
    drive();
  endtask

  task automatic run_idle(input int max, output bit to);
    to = 1'b1;
    for (int c = 0; c < max; c++) begin
      if (idle()) begin
        to = 1'b0;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0; plen[i] = 0; pos[i] = 0; seq[i] = 0;
    end
    link_if.fillStatus.full  = 1'b0;
    link_if.fillStatus.empty = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete(); grants.delete(); blens.delete(); wcyc.delete();
    n_writes = 0;
  endtask

  // Monitor: per-cycle invariants and scoreboard pop on each write.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && reset_n) begin
        tests++;
        if (!$onehot0(ack) || link_if.read !== 1'b0 ||
            ack !== (link_if.write ? (4'b0001 << owner) : 4'b0000) ||
            (!busy && (link_if.write !== 1'b0 || link_if.datain !== 32'h0)) ||
            (busy && link_if.datain !== data[owner])) begin
          fails++;
          $display("FAIL invariant cyc=%0d ack=%b write=%b owner=%0d busy=%b datain=%h",
                   cyc, ack, link_if.write, owner, busy, link_if.datain);
        end
        if (prev_busy && !busy) blens.push_back(bl);
        if (busy && !prev_busy) begin
          grants.push_back(int'(owner));
          bl = 0;
        end
        if (link_if.write === 1'b1) begin
          bl++;
          n_writes++;
          wcyc.push_back(cyc);
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_write got=%h expected=none", link_if.datain);
          end else begin
            logic [WIDTH-1:0] exp_w;
            exp_w = sb.pop_front();
            if (link_if.datain !== exp_w) begin
              fails++;
              $display("FAIL sb_data got=%h expected=%h", link_if.datain, exp_w);
            end
          end
        end
        prev_busy = busy;
      end else begin
        prev_busy = 1'b0;
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    link_if.fillStatus.full  = 1'b0;
    link_if.fillStatus.empty = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 1; plen[i] = 1; pos[i] = 0; seq[i] = 0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      fails++; $display("FAIL reset_state busy=%b owner=%0d expected busy=0 owner=0", busy, owner);
    end
    tests++;
    if (ack !== 4'b0000 || link_if.write !== 1'b0) begin
      fails++; $display("FAIL reset_ack ack=%b write=%b expected 0000/0", ack, link_if.write);
    end
    tests++;
    if (link_if.read !== 1'b0 || link_if.datain !== 32'h0) begin
      fails++; $display("FAIL reset_link read=%b datain=%h expected 0/0", link_if.read, link_if.datain);
    end
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    drive();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    n_writes = 0;
    repeat (3) step();
    tests++;
    if (busy !== 1'b0 || n_writes != 0) begin
      fails++; $display("FAIL idle_no_req busy=%b writes=%0d expected 0/0", busy, n_writes);
    end
  endtask

  task automatic test_two_packets();
    bit to;
    apply_reset();
    left[0] = 3; plen[0] = 3; left[2] = 3; plen[2] = 3;
    for (int s = 0; s < 3; s++) sb.push_back(word(0, s));
    for (int s = 0; s < 3; s++) sb.push_back(word(2, s));
    drive();
    run_idle(100, to);
    tests++;
    if (to || n_writes != 6 || sb.size() != 0) begin
      fails++; $display("FAIL two_pkt_count timeout=%0d writes=%0d left_in_sb=%0d expected 0/6/0", to, n_writes, sb.size());
    end
    tests++;
    if (qcode(grants) != 64'h13 || qcode(blens) != 64'h44) begin
      fails++; $display("FAIL two_pkt_order grants=%h blens=%h expected 13/44", qcode(grants), qcode(blens));
    end
    tests++;
    if (wcyc.size() != 6 || wcyc[5] - wcyc[0] != 6 || wcyc[3] - wcyc[2] != 2) begin
      fails++; $display("FAIL two_pkt_gap writes=%0d expected 6 writes over 7 cycles with 1 gap", wcyc.size());
    end
  endtask

  task automatic test_maxburst();
    bit inj = 1'b0;
    bit to  = 1'b1;
    apply_reset();
    left[1] = 20; plen[1] = 0;
    for (int s = 0; s < 8; s++) sb.push_back(word(1, s));
    for (int s = 0; s < 2; s++) sb.push_back(word(3, s));
    for (int s = 8; s < 20; s++) sb.push_back(word(1, s));
    drive();
    for (int c = 0; c < 300; c++) begin
      if (idle()) begin
        to = 1'b0;
        break;
      end
      step();
      if (n_writes == 3 && !inj) begin
        inj = 1'b1;
        left[3] = 2; plen[3] = 2;
        drive();
      end
    end
    step();
    tests++;
    if (to || n_writes != 22 || sb.size() != 0) begin
      fails++; $display("FAIL maxburst_count timeout=%0d writes=%0d left_in_sb=%0d expected 0/22/0", to, n_writes, sb.size());
    end
    tests++;
    if (qcode(grants) != 64'h2422) begin
      fails++; $display("FAIL maxburst_grants got=%h expected 2422", qcode(grants));
    end
    tests++;
    if (qcode(blens) != 64'h9395) begin
      fails++; $display("FAIL maxburst_lens got=%h expected 9395", qcode(blens));
    end
  endtask

  task automatic test_backpressure();
    bit stalled = 1'b0;
    bit to;
    apply_reset();
    left[2] = 6; plen[2] = 6;
    for (int s = 0; s < 6; s++) sb.push_back(word(2, s));
    drive();
    for (int c = 0; c < 50 && !stalled; c++) begin
      step();
      if (n_writes == 2) begin
        stalled = 1'b1;
        link_if.fillStatus.full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          tests++;
          if (link_if.write !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1 ||
              owner !== 2'd2 || dut.burst_cnt_q !== 4'd2) begin
            fails++;
            $display("FAIL stall k=%0d write=%b ack=%b busy=%b owner=%0d cnt=%0d expected 0/0000/1/2/2",
                     k, link_if.write, ack, busy, owner, dut.burst_cnt_q);
          end
          step();
        end
        link_if.fillStatus.full = 1'b0;
      end
    end
    run_idle(100, to);
    tests++;
    if (!stalled || to || n_writes != 6 || sb.size() != 0) begin
      fails++; $display("FAIL stall_resume stalled=%0d timeout=%0d writes=%0d expected 1/0/6", stalled, to, n_writes);
    end
    tests++;
    if (qcode(grants) != 64'h3 || qcode(blens) != 64'h7) begin
      fails++; $display("FAIL stall_burst grants=%h blens=%h expected 3/7", qcode(grants), qcode(blens));
    end
  endtask

  task automatic test_all_req();
    bit to;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 4; plen[i] = 2;
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) begin
        sb.push_back(word(i, 2 * r));
        sb.push_back(word(i, 2 * r + 1));
      end
    drive();
    run_idle(200, to);
    tests++;
    if (to || n_writes != 16 || sb.size() != 0) begin
      fails++; $display("FAIL all_req_count timeout=%0d writes=%0d expected 0/16", to, n_writes);
    end
    tests++;
    if (qcode(grants) != 64'h12341234 || qcode(blens) != 64'h33333333) begin
      fails++; $display("FAIL all_req_order grants=%h blens=%h expected 12341234/33333333", qcode(grants), qcode(blens));
    end
  endtask

  task automatic test_reset_mid_burst();
    bit to = 1'b1;
    apply_reset();
    left[0] = 1; plen[0] = 1; left[2] = 6; plen[2] = 6;
    sb.push_back(word(0, 0)); sb.push_back(word(2, 0)); sb.push_back(word(2, 1));
    sb.push_back(word(0, 1)); sb.push_back(word(1, 0));
    drive();
    for (int c = 0; c < 50; c++) begin
      step();
      if (n_writes == 3) begin
        to = 1'b0;
        break;
      end
    end
    tests++;
    if (to || link_if.write !== 1'b1 || owner !== 2'd2) begin
      fails++; $display("FAIL pre_reset_burst timeout=%0d write=%b owner=%0d expected 0/1/2", to, link_if.write, owner);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (ack !== 4'b0000 || link_if.write !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL async_reset ack=%b write=%b busy=%b expected 0000/0/0", ack, link_if.write, busy);
    end
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    grants.delete(); blens.delete();
    left[0] = 1; plen[0] = 1; pos[0] = 0;
    left[1] = 1; plen[1] = 1; pos[1] = 0;
    drive();
    run_idle(100, to);
    tests++;
    if (to || qcode(grants) != 64'h12 || n_writes != 5 || sb.size() != 0) begin
      fails++; $display("FAIL post_reset_grant timeout=%0d grants=%h writes=%0d expected 0/12/5", to, qcode(grants), n_writes);
    end
  endtask

  task automatic test_withdraw();
    bit inj = 1'b0;
    bit to  = 1'b1;
    apply_reset();
    left[1] = 2; plen[1] = 0; left[2] = 3; plen[2] = 3;
    sb.push_back(word(1, 0)); sb.push_back(word(1, 1));
    for (int s = 0; s < 3; s++) sb.push_back(word(2, s));
    sb.push_back(word(0, 0));
    drive();
    for (int c = 0; c < 100; c++) begin
      if (idle()) begin
        to = 1'b0;
        break;
      end
      step();
      if (n_writes == 1 && !inj) begin
        inj = 1'b1;
        left[0] = 1; plen[0] = 1;
        drive();
      end
    end
    step();
    tests++;
    if (to || n_writes != 6 || sb.size() != 0) begin
      fails++; $display("FAIL withdraw_count timeout=%0d writes=%0d expected 0/6", to, n_writes);
    end
    tests++;
    if (qcode(grants) != 64'h231 || qcode(blens) != 64'h342) begin
      fails++; $display("FAIL withdraw_rotate grants=%h blens=%h expected 231/342", qcode(grants), qcode(blens));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_packets();
    test_maxburst();
    test_backpressure();
    test_all_req();
    test_reset_mid_burst();
    test_withdraw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
